pdm_frame_sender: RTL and testbench



---
 rtl/pdm_pkg.sv | 26 ++
 rtl/pdm_frame_sender_fifo.sv | 57 +++++
 rtl/pdm_frame_sender.sv | 212 +++++++++++++++++++++
 tb/tb_pdm_frame_sender.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM frame sender: framer states and header layout.
package pdm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEQ_HI,
    SEQ_LO,
    FLAGS,
    PAYLOAD
  } framer_state_t;

  localparam int SEQ_W           = 16;
  localparam int FLAGS_W         = 8;
  localparam int FLAGS_OVF_BIT   = 7;
  localparam int FLAGS_LINES_LSB = 0;
  localparam int FLAGS_LINES_W   = 4;

  function automatic logic [FLAGS_W-1:0] make_flags(input logic ovf, input int lines);
    logic [FLAGS_W-1:0] f;
    f = '0;
    f[FLAGS_OVF_BIT] = ovf;
    f[FLAGS_LINES_LSB +: FLAGS_LINES_W] = FLAGS_LINES_W'($clog2(lines));
    return f;
  endfunction

endpackage

// File: rtl/pdm_frame_sender_fifo.sv
// Byte FIFO with RAM-style storage and a registered read port (data appears 1 clk after pop).
module byte_fifo #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wr_data,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [7:0]    rd_data_reg;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  // A pop frees the slot in the same cycle, so a push into a full FIFO is still taken.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
      if (wr_en && !rd_en) count_reg <= count_reg + 1'b1;
      else if (!wr_en && rd_en) count_reg <= count_reg - 1'b1;
    end
  end

  assign rd_data = rd_data_reg;
  assign count   = count_reg;

endmodule

// File: rtl/pdm_frame_sender.sv
// Multi-line PDM capture: divider, bit packer, byte FIFO and header framer on a valid/ready byte stream.
module pdm_frame_sender
  import pdm_pkg::*;
#(
  parameter int               LINES         = 1,
  parameter int               PDM_DIV       = 25,
  parameter int               PAYLOAD_BYTES = 64,
  parameter int               FIFO_DEPTH    = 256,
  parameter logic [SEQ_W-1:0] SEQ_INIT      = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             au_pdm_clk,
  input  logic [LINES-1:0] au_pdm_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_first,
  output logic             tx_last,
  output logic [7:0]       overflow_cnt,
  output logic             debug
);

  localparam int CAPS  = 8 / LINES;
  localparam int DIV_W = $clog2(PDM_DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int REM_W = $clog2(PAYLOAD_BYTES + 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             pdm_clk_reg;
  logic [3:0]       cap_cnt_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       byte_reg;
  logic             push_reg;
  logic             half_end;
  logic [LINES-1:0] cap_bits;
  logic [7+LINES:0] shift_cat;
  logic [7:0]       shift_next;

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_cap
      assign cap_bits[LINES-1-gi] = au_pdm_data[gi];
    end
  endgenerate

  assign half_end   = enable && (div_cnt_reg == DIV_W'(PDM_DIV - 1));
  assign shift_cat  = {shift_reg, cap_bits};
  assign shift_next = shift_cat[7:0];

  // Each half-period ends with a capture; which phase it was only labels the channel (A/B).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
      pdm_clk_reg <= 1'b0;
      cap_cnt_reg <= '0;
      shift_reg   <= '0;
      byte_reg    <= '0;
      push_reg    <= 1'b0;
    end else begin
      push_reg <= 1'b0;
      if (!enable) begin
        div_cnt_reg <= '0;
        pdm_clk_reg <= 1'b0;
        cap_cnt_reg <= '0;
        shift_reg   <= '0;
      end else if (half_end) begin
        div_cnt_reg <= '0;
        pdm_clk_reg <= ~pdm_clk_reg;
        shift_reg   <= shift_next;
        if (cap_cnt_reg == 4'(CAPS - 1)) begin
          cap_cnt_reg <= '0;
          byte_reg    <= shift_next;
          push_reg    <= 1'b1;
        end else begin
          cap_cnt_reg <= cap_cnt_reg + 4'd1;
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
    end
  end

  logic [7:0]       fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             pop_req;
  logic             fifo_pop;
  logic             drop;

  assign fifo_pop = pop_req && !fifo_empty;
  assign drop     = push_reg && fifo_full && !fifo_pop;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_reg),
    .wr_data (byte_reg),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  framer_state_t    state_reg, state_next;
  logic [SEQ_W-1:0] seq_reg, seq_next;
  logic [REM_W-1:0] rem_reg, rem_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic             tx_valid_reg, tx_valid_next;
  logic             tx_first_reg, tx_first_next;
  logic             tx_last_reg, tx_last_next;
  logic             ovf_reg;
  logic             ovf_clear;
  logic [7:0]       overflow_cnt_reg;
  logic             xfer;

  assign xfer = tx_valid_reg && tx_ready;

  // tx_data is the output register; fifo_rd_data is always prefetched one byte ahead of it.
  always_comb begin
    state_next    = state_reg;
    seq_next      = seq_reg;
    rem_next      = rem_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    tx_first_next = tx_first_reg;
    tx_last_next  = tx_last_reg;
    pop_req       = 1'b0;
    ovf_clear     = 1'b0;
    case (state_reg)
      IDLE: if (fifo_count >= CNT_W'(PAYLOAD_BYTES)) begin
        state_next    = SEQ_HI;
        tx_data_next  = seq_reg[15:8];
        tx_valid_next = 1'b1;
        tx_first_next = 1'b1;
        tx_last_next  = 1'b0;
      end
      SEQ_HI: if (xfer) begin
        state_next    = SEQ_LO;
        tx_data_next  = seq_reg[7:0];
        tx_first_next = 1'b0;
      end
      SEQ_LO: if (xfer) begin
        state_next   = FLAGS;
        tx_data_next = make_flags(ovf_reg, LINES);
        pop_req      = 1'b1;
      end
      FLAGS: if (xfer) begin
        state_next   = PAYLOAD;
        tx_data_next = fifo_rd_data;
        tx_last_next = (PAYLOAD_BYTES == 1);
        rem_next     = REM_W'(PAYLOAD_BYTES - 1);
        pop_req      = (PAYLOAD_BYTES > 1);
        // Only clear what the header reported; a later drop stays pending for the next frame.
        ovf_clear    = tx_data_reg[FLAGS_OVF_BIT];
      end
      PAYLOAD: if (xfer) begin
        if (tx_last_reg) begin
          state_next    = IDLE;
          tx_valid_next = 1'b0;
          tx_last_next  = 1'b0;
          tx_data_next  = '0;
          seq_next      = seq_reg + 16'd1;
        end else begin
          tx_data_next = fifo_rd_data;
          tx_last_next = (rem_reg == REM_W'(1));
          rem_next     = rem_reg - REM_W'(1);
          pop_req      = (rem_reg > REM_W'(1));
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      seq_reg          <= SEQ_INIT;
      rem_reg          <= '0;
      tx_data_reg      <= '0;
      tx_valid_reg     <= 1'b0;
      tx_first_reg     <= 1'b0;
      tx_last_reg      <= 1'b0;
      ovf_reg          <= 1'b0;
      overflow_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      seq_reg      <= seq_next;
      rem_reg      <= rem_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      tx_first_reg <= tx_first_next;
      tx_last_reg  <= tx_last_next;
      if (drop) ovf_reg <= 1'b1;
      else if (ovf_clear) ovf_reg <= 1'b0;
      if (drop && overflow_cnt_reg != 8'hFF) overflow_cnt_reg <= overflow_cnt_reg + 8'd1;
    end
  end

  assign au_pdm_clk   = pdm_clk_reg;
  assign tx_data      = tx_data_reg;
  assign tx_valid     = tx_valid_reg;
  assign tx_first     = tx_first_reg;
  assign tx_last      = tx_last_reg;
  assign overflow_cnt = overflow_cnt_reg;
  assign debug        = (state_reg != IDLE);

endmodule

// File: tb/tb_pdm_frame_sender.sv
// Bench for pdm_frame_sender: two configurations checked against a frame-level model every cycle.
module tb_pdm_frame_sender;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [NI];
  logic       enable [NI];
  logic       ready [NI];
  logic [0:0] data0 = 1'b1;
  logic [1:0] data1 = 2'b01;
  logic       pdm [NI];
  logic [7:0] txd [NI];
  logic       txv [NI];
  logic       txf [NI];
  logic       txl [NI];
  logic       dbg [NI];
  logic [7:0] ovc [NI];

  pdm_frame_sender #(.LINES(1), .PDM_DIV(2), .PAYLOAD_BYTES(4), .FIFO_DEPTH(16)) u0 (
    .clk(clk), .rst(rst[0]), .enable(enable[0]), .au_pdm_clk(pdm[0]), .au_pdm_data(data0),
    .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(ready[0]), .tx_first(txf[0]),
    .tx_last(txl[0]), .overflow_cnt(ovc[0]), .debug(dbg[0]));

  pdm_frame_sender #(.LINES(2), .PDM_DIV(2), .PAYLOAD_BYTES(2), .FIFO_DEPTH(16),
                     .SEQ_INIT(16'hFFFF)) u1 (
    .clk(clk), .rst(rst[1]), .enable(enable[1]), .au_pdm_clk(pdm[1]), .au_pdm_data(data1),
    .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(ready[1]), .tx_first(txf[1]),
    .tx_last(txl[1]), .overflow_cnt(ovc[1]), .debug(dbg[1]));

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  int          pos [NI];
  int          frames [NI];
  int          ovf_req [NI];
  int          ovf_srv [NI];
  int          last_rise [NI];
  logic [15:0] exp_seq [NI];
  logic        pv_valid [NI];
  logic        pv_first [NI];
  logic        pv_last [NI];
  logic [7:0]  pv_data [NI];
  logic        pdm_prev [NI];
  logic [7:0]  rec [NI][8];
  logic [7:0]  fbits [NI];
  logic [7:0]  lbits [NI];
  logic [15:0] hdr_log [NI][16];
  logic [7:0]  flags_log [NI][16];

  // Per-configuration facts: all-ones data on one line gives FF, line0=1/line1=0 gives 10 pairs = AA.
  function automatic int pay_n(input int i);
    return (i == 0) ? 4 : 2;
  endfunction
  function automatic logic [7:0] pay_b(input int i);
    return (i == 0) ? 8'hFF : 8'hAA;
  endfunction
  function automatic logic [3:0] lines_lg(input int i);
    return (i == 0) ? 4'd0 : 4'd1;
  endfunction
  function automatic logic [15:0] seq_init(input int i);
    return (i == 0) ? 16'h0000 : 16'hFFFF;
  endfunction

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_inst(input int i);
    logic [7:0] eb;
    int p;
    p = pay_n(i);
    if (rst[i]) begin
      pos[i] = 0; exp_seq[i] = seq_init(i); ovf_srv[i] = ovf_req[i];
      pv_valid[i] = 1'b0; last_rise[i] = -1; pdm_prev[i] = 1'b0;
      return;
    end
    if (pv_valid[i]) begin
      if (ready[i]) begin
        case (pos[i])
          0:       eb = exp_seq[i][15:8];
          1:       eb = exp_seq[i][7:0];
          2:       eb = {ovf_req[i] != ovf_srv[i], 3'b000, lines_lg(i)};
          default: eb = pay_b(i);
        endcase
        chk_eq($sformatf("u%0d_frame%0d_byte%0d", i, frames[i], pos[i]),
               {22'd0, pv_first[i], pv_last[i], pv_data[i]},
               {22'd0, pos[i] == 0, pos[i] == p + 2, eb});
        if (frames[i] == 0 && pos[i] < 8) begin
          rec[i][pos[i]]   = pv_data[i];
          fbits[i][pos[i]] = pv_first[i];
          lbits[i][pos[i]] = pv_last[i];
        end
        if (frames[i] < 16) begin
          if (pos[i] == 0) hdr_log[i][frames[i]][15:8] = pv_data[i];
          if (pos[i] == 1) hdr_log[i][frames[i]][7:0] = pv_data[i];
          if (pos[i] == 2) flags_log[i][frames[i]] = pv_data[i];
        end
        if (pos[i] == 2) ovf_srv[i] = ovf_req[i];
        if (pos[i] == p + 2) begin
          pos[i] = 0; exp_seq[i] = exp_seq[i] + 16'd1; frames[i]++;
        end else begin
          pos[i]++;
        end
      end else begin
        chk_eq($sformatf("u%0d_hold", i), {21'd0, txv[i], txf[i], txl[i], txd[i]},
               {21'd0, 1'b1, pv_first[i], pv_last[i], pv_data[i]});
      end
    end
    if (txv[i]) chk_eq($sformatf("u%0d_debug", i), {31'd0, dbg[i]}, 32'd1);
    pv_valid[i] = txv[i]; pv_first[i] = txf[i]; pv_last[i] = txl[i]; pv_data[i] = txd[i];
    if (!enable[i]) begin
      chk_eq($sformatf("u%0d_pdm_idle", i), {31'd0, pdm[i]}, 32'd0);
      last_rise[i] = -1;
    end else if (pdm[i] && !pdm_prev[i]) begin
      if (last_rise[i] >= 0) chk_eq($sformatf("u%0d_pdm_period", i), cyc - last_rise[i], 32'd4);
      last_rise[i] = cyc;
    end
    pdm_prev[i] = pdm[i];
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) check_inst(i);
  endtask

  task automatic check_reset_outputs(input int i);
    chk_eq($sformatf("u%0d_reset_outputs", i),
           {12'd0, pdm[i], txv[i], txf[i], txl[i], dbg[i], ovc[i], txd[i]}, 32'd0);
  endtask

  task automatic wait_frames(input int i, input int n, input int budget);
    int k;
    k = 0;
    while (frames[i] < n && k < budget) begin
      tick();
      k++;
    end
    chk_eq($sformatf("u%0d_frames_reached_%0d", i, n), {31'd0, frames[i] >= n}, 32'd1);
  endtask

  initial begin
    int f0;
    int k;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; enable[i] = 1'b0; ready[i] = 1'b0;
      pos[i] = 0; frames[i] = 0; ovf_req[i] = 0; ovf_srv[i] = 0; last_rise[i] = -1;
      exp_seq[i] = seq_init(i); pv_valid[i] = 1'b0; pv_first[i] = 1'b0; pv_last[i] = 1'b0;
      pv_data[i] = '0; pdm_prev[i] = 1'b0; fbits[i] = '0; lbits[i] = '0;
      for (int j = 0; j < 8; j++) rec[i][j] = '0;
      for (int j = 0; j < 16; j++) begin hdr_log[i][j] = '0; flags_log[i][j] = '0; end
    end
    repeat (3) tick();
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();

    // Free-running capture with the sink always ready.
    for (int i = 0; i < NI; i++) begin enable[i] = 1'b1; ready[i] = 1'b1; end
    k = 0;
    while ((frames[0] < 2 || frames[1] < 2) && k < 600) begin tick(); k++; end
    chk_eq("both_two_frames", {31'd0, frames[0] >= 2 && frames[1] >= 2}, 32'd1);
    enable[1] = 1'b0;
    chk_eq("u0_f0_b0", rec[0][0], 8'h00);
    chk_eq("u0_f0_b1", rec[0][1], 8'h00);
    chk_eq("u0_f0_flags", rec[0][2], 8'h00);
    chk_eq("u0_f0_b3", rec[0][3], 8'hFF);
    chk_eq("u0_f0_b6", rec[0][6], 8'hFF);
    chk_eq("u0_f0_first_bits", fbits[0], 8'h01);
    chk_eq("u0_f0_last_bits", lbits[0], 8'h40);
    chk_eq("u0_f1_seq", hdr_log[0][1], 16'h0001);
    chk_eq("u1_f0_seq", hdr_log[1][0], 16'hFFFF);
    chk_eq("u1_f1_seq", hdr_log[1][1], 16'h0000);
    chk_eq("u1_f0_flags", rec[1][2], 8'h01);
    chk_eq("u1_f0_b3", rec[1][3], 8'hAA);
    chk_eq("u1_f0_last_bits", lbits[1], 8'h10);

    // Sink ready only every other cycle.
    k = 0;
    while (frames[0] < 4 && k < 600) begin tick(); ready[0] = ~ready[0]; k++; end
    chk_eq("u0_toggle_frames", {31'd0, frames[0] >= 4}, 32'd1);
    ready[0] = 1'b1;

    // Abort a frame part-way through its payload.
    k = 0;
    while (!(pos[0] >= 4 && txv[0]) && k < 300) begin tick(); k++; end
    chk_eq("u0_reached_payload", {31'd0, pos[0] >= 4 && txv[0]}, 32'd1);
    rst[0] = 1'b1; enable[0] = 1'b0; ready[0] = 1'b0;
    #1;
    check_reset_outputs(0);
    tick(); tick();
    rst[0] = 1'b0;
    tick();

    // Stalled sink: 19 bytes into a 16-byte FIFO drops exactly 3.
    enable[0] = 1'b1;
    repeat (19 * 16 + 8) tick();
    enable[0] = 1'b0;
    ovf_req[0]++;
    chk_eq("u0_overflow_cnt", ovc[0], 8'd3);
    f0 = frames[0];
    ready[0] = 1'b1;
    wait_frames(0, f0 + 4, 400);
    chk_eq("u0_post_rst_seq", hdr_log[0][f0], 16'h0000);
    chk_eq("u0_ovf_flags", flags_log[0][f0], 8'h80);
    chk_eq("u0_ovf_cleared_flags", flags_log[0][f0 + 1], 8'h00);
    chk_eq("u0_overflow_cnt_hold", ovc[0], 8'd3);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
